// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage access sequencer for the SEQ pipeline.
// Decodes the access at the start edge, issues a held request to the data RAM
// and waits for its acknowledge, then pulses done for one cycle.
// Optional build macro MEM_ACCESS_TIMEOUT_EN adds a 255-cycle acknowledge timeout.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic        mreq,
  output logic        mwe,
  output logic [63:0] maddr,
  output logic [63:0] mwdata,
  input  logic        mack,
  input  logic [63:0] mrdata,
  output logic [63:0] valM,
  output logic        busy,
  output logic        done,
  output logic        dmem_error
);

  localparam int unsigned AW       = 64;
  localparam int unsigned DW       = 64;
  localparam logic [AW-1:0] ADDR_LIMIT = AW'(1024);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state, state_nxt;
  logic          mreq_nxt, mwe_nxt, busy_nxt, done_nxt, err_nxt;
  logic [AW-1:0] maddr_nxt;
  logic [DW-1:0] mwdata_nxt, valm_nxt;

  logic          dec_access, dec_write;
  logic [AW-1:0] dec_addr;
  logic [DW-1:0] dec_wdata;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(254);
  logic [CW-1:0] cnt, cnt_nxt;
`endif

  // Access decode from the instruction code
  always_comb begin
    dec_access = 1'b0;
    dec_write  = 1'b0;
    dec_addr   = '0;
    dec_wdata  = '0;
    case (icode)
      4'd4, 4'd10: begin dec_access = 1'b1; dec_write = 1'b1; dec_addr = valE; dec_wdata = valA; end
      4'd8:        begin dec_access = 1'b1; dec_write = 1'b1; dec_addr = valE; dec_wdata = valP; end
      4'd5:        begin dec_access = 1'b1; dec_addr = valE; end
      4'd9, 4'd11: begin dec_access = 1'b1; dec_addr = valA; end
      default:     ;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    mreq_nxt   = mreq;
    mwe_nxt    = mwe;
    maddr_nxt  = maddr;
    mwdata_nxt = mwdata;
    valm_nxt   = valM;
    err_nxt    = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    cnt_nxt    = cnt;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (!dec_access) begin
            state_nxt = DONE;
          end else if (dec_addr >= ADDR_LIMIT) begin
            state_nxt = DONE;
            err_nxt   = 1'b1;
          end else begin
            state_nxt  = REQ;
            mreq_nxt   = 1'b1;
            mwe_nxt    = dec_write;
            maddr_nxt  = dec_addr;
            mwdata_nxt = dec_wdata;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_nxt    = '0;
`endif
          end
        end
      end
      REQ: begin
        if (mack) begin
          state_nxt  = DONE;
          mreq_nxt   = 1'b0;
          mwe_nxt    = 1'b0;
          maddr_nxt  = '0;
          mwdata_nxt = '0;
          if (!mwe) valm_nxt = mrdata;
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        else if (cnt == TIMEOUT_LAST) begin
          // This cycle brings the count to 255: abandon the access
          state_nxt  = DONE;
          err_nxt    = 1'b1;
          mreq_nxt   = 1'b0;
          mwe_nxt    = 1'b0;
          maddr_nxt  = '0;
          mwdata_nxt = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
`endif
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt  = IDLE;
        mreq_nxt   = 1'b0;
        mwe_nxt    = 1'b0;
        maddr_nxt  = '0;
        mwdata_nxt = '0;
      end
    endcase
    done_nxt = (state_nxt == DONE);
    busy_nxt = (state_nxt != IDLE);
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mreq       <= 1'b0;
      mwe        <= 1'b0;
      maddr      <= '0;
      mwdata     <= '0;
      valM       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dmem_error <= 1'b0;
    end else begin
      state      <= state_nxt;
      mreq       <= mreq_nxt;
      mwe        <= mwe_nxt;
      maddr      <= maddr_nxt;
      mwdata     <= mwdata_nxt;
      valM       <= valm_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      dmem_error <= err_nxt;
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  // Acknowledge-wait counter
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized checks of mem_access_ctrl
// against a transaction-level reference model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, mack;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP, mrdata;
  logic        mreq, mwe, busy, done, dmem_error;
  logic [63:0] maddr, mwdata, valM;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_valm = '0;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode),
    .valE(valE), .valA(valA), .valP(valP),
    .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata),
    .mack(mack), .mrdata(mrdata), .valM(valM),
    .busy(busy), .done(done), .dmem_error(dmem_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model of what an instruction asks of memory
  task automatic model(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p, output bit acc, output bit wr,
                       output logic [63:0] ad, output logic [63:0] wd);
    acc = 1'b1; wr = 1'b0; ad = e; wd = '0;
    if (ic == 4'd4 || ic == 4'd10) begin wr = 1'b1; wd = a; end
    else if (ic == 4'd8)           begin wr = 1'b1; wd = p; end
    else if (ic == 4'd5)           begin ad = e; end
    else if (ic == 4'd9 || ic == 4'd11) begin ad = a; end
    else begin acc = 1'b0; ad = '0; end
  endtask

  function automatic logic [63:0] pick_addr();
    logic [63:0] r;
    case ($urandom_range(0, 4))
      0: r = 64'd1023;
      1: r = 64'd1024;
      2: r = {$urandom, $urandom};
      default: r = 64'($urandom_range(0, 1023));
    endcase
    return r;
  endfunction

  // One full transaction: start pulse, optional RAM handshake, done, back to idle
  task automatic do_txn(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                        input logic [63:0] p, input int dly, input logic [63:0] rd,
                        input bit noisy);
    bit acc, wr, err;
    logic [63:0] ad, wd;
    model(ic, e, a, p, acc, wr, ad, wd);
    err = acc && (ad >= 64'd1024);
    start = 1'b1; icode = ic; valE = e; valA = a; valP = p;
    mack = noisy;   // mack alongside start in IDLE must be ignored
    mrdata = {$urandom, $urandom};
    step();
    start = 1'b0; mack = 1'b0;
    if (!acc || err) begin
      chk("fast_done", 64'(done), 64'd1);
      chk("fast_err", 64'(dmem_error), 64'(err));
      chk("fast_mreq", 64'(mreq), 64'd0);
      chk("fast_busy", 64'(busy), 64'd1);
    end else begin
      for (int k = 0; k <= dly; k++) begin
        chk("req_mreq", 64'(mreq), 64'd1);
        chk("req_mwe", 64'(mwe), 64'(wr));
        chk("req_maddr", maddr, ad);
        chk("req_mwdata", mwdata, wr ? wd : 64'd0);
        chk("req_busy", 64'(busy), 64'd1);
        chk("req_done", 64'(done), 64'd0);
        if (noisy) begin
          start = 1'($urandom_range(0, 1));
          icode = 4'($urandom); valE = {$urandom, $urandom}; valA = {$urandom, $urandom};
        end
        if (k == dly) begin mack = 1'b1; mrdata = rd; end
        else begin mack = 1'b0; mrdata = {$urandom, $urandom}; end
        step();
        mack = 1'b0; start = 1'b0;
      end
      chk("ack_done", 64'(done), 64'd1);
      chk("ack_err", 64'(dmem_error), 64'd0);
      chk("ack_mreq", 64'(mreq), 64'd0);
      chk("ack_maddr", maddr, 64'd0);
      chk("ack_mwdata", mwdata, 64'd0);
      if (!wr) exp_valm = rd;
    end
    chk("valM", valM, exp_valm);
    if (noisy) mack = 1'b1;   // mack in DONE must be ignored
    step();
    mack = 1'b0;
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_mreq", 64'(mreq), 64'd0);
    chk("idle_valM", valM, exp_valm);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mack = 1'b0; icode = '0;
    valE = '0; valA = '0; valP = '0; mrdata = '0;
    step(); step();
    chk("rst_mreq", 64'(mreq), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valM", valM, 64'd0);
    chk("rst_maddr", maddr, 64'd0);
    rst = 1'b0;
    step();

    // rmmovq: write 0xAA at 16, acked after 3 REQ cycles
    do_txn(4'd4, 64'd16, 64'hAA, 64'd0, 2, 64'h5555, 1'b0);
    // ret: read at valA=8, ack in first REQ cycle
    do_txn(4'd9, 64'd0, 64'd8, 64'd0, 0, 64'h1234, 1'b0);
    // nop: no access
    do_txn(4'd1, 64'd0, 64'd0, 64'd0, 0, 64'd0, 1'b0);
    // mrmovq at 1024: out of range
    do_txn(4'd5, 64'd1024, 64'd0, 64'd0, 0, 64'd0, 1'b0);
    // mrmovq at 1023: last legal word
    do_txn(4'd5, 64'd1023, 64'd0, 64'd0, 1, 64'hFEED, 1'b1);

    // Reset during REQ of a call, with mack on the same edge
    start = 1'b1; icode = 4'd8; valE = 64'd40; valP = 64'h77;
    step();
    start = 1'b0;
    chk("call_mreq", 64'(mreq), 64'd1);
    step();
    rst = 1'b1; mack = 1'b1; mrdata = 64'hDEAD;
    step();
    rst = 1'b0; mack = 1'b0;
    exp_valm = '0;
    chk("mid_rst_mreq", 64'(mreq), 64'd0);
    chk("mid_rst_maddr", maddr, 64'd0);
    chk("mid_rst_mwdata", mwdata, 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valM", valM, 64'd0);
    step();
    chk("post_rst_done", 64'(done), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);

    // Randomized transactions
    for (int t = 0; t < 60; t++) begin
      do_txn(4'($urandom), pick_addr(), pick_addr(), {$urandom, $urandom},
             int'($urandom_range(0, 4)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    // No acknowledge ever arrives
    start = 1'b1; icode = 4'd5; valE = 64'd100;
    step();
    start = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    for (int k = 0; k < 254; k++) step();
    chk("to_pre_done", 64'(done), 64'd0);
    chk("to_pre_mreq", 64'(mreq), 64'd1);
    step();
    chk("to_done", 64'(done), 64'd1);
    chk("to_err", 64'(dmem_error), 64'd1);
    chk("to_mreq", 64'(mreq), 64'd0);
    chk("to_valM", valM, exp_valm);
`else
    for (int k = 0; k < 300; k++) step();
    chk("hang_busy", 64'(busy), 64'd1);
    chk("hang_mreq", 64'(mreq), 64'd1);
    chk("hang_done", 64'(done), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
